// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and sizing helpers for the debounce scheduler
package debounce_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Counter width for a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The all-ones history value, 2**len-1.
    function automatic logic [63:0] hist_ones(input int len);
        return (64'd1 << len) - 64'd1;
    endfunction

endpackage

// File: rtl/debounce_eval.sv
// rtl/debounce_eval.sv - shared combinational shift/compare engine for one channel
module debounce_eval
    import debounce_pkg::*;
#(
    parameter int HIST_LEN = 8
) (
    input  logic [HIST_LEN-2:0] hist_i,
    input  logic                sample_i,
    input  logic                level_i,
    output logic [HIST_LEN-2:0] new_hist_o,
    output logic                level_o,
    output logic                rise_o,
    output logic                fall_o
);

    localparam logic [HIST_LEN-1:0] HIST_ONES = HIST_LEN'(hist_ones(HIST_LEN));

    logic [HIST_LEN-1:0] window;

    // The decision window is the newest sample plus the HIST_LEN-1 stored ones.
    assign window     = {hist_i, sample_i};
    assign new_hist_o = window[HIST_LEN-2:0];

    always_comb begin
        level_o = level_i;
        rise_o  = 1'b0;
        fall_o  = 1'b0;
        if (window == HIST_ONES) begin
            level_o = 1'b1;
            rise_o  = ~level_i;
        end else if (window == '0) begin
            level_o = 1'b0;
            fall_o  = level_i;
        end
    end

endmodule

// File: rtl/debounce_scheduler.sv
// rtl/debounce_scheduler.sv - round-robin time-multiplexed debouncer for front-panel inputs
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int HIST_LEN = 8,
    parameter int TICK_DIV = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [N_INPUTS-1:0] in_raw,
    output logic [N_INPUTS-1:0] debounced,
    output logic [N_INPUTS-1:0] rise,
    output logic [N_INPUTS-1:0] fall,
    output logic                scan_done
);

    localparam int PW = cnt_width(TICK_DIV);
    localparam int CW = cnt_width(N_INPUTS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CH_LAST    = CW'(N_INPUTS - 1);

    state_e              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [N_INPUTS-1:0] sync1_q, sync2_q;
    logic [N_INPUTS-1:0] deb_q, rise_q, fall_q;
    logic                scan_done_q;

    // The oldest sample never influences a later decision, so only HIST_LEN-1 are kept.
    logic [HIST_LEN-2:0] hist_q [N_INPUTS];

    logic                tick;
    logic                last_ch;
    logic [HIST_LEN-2:0] eval_hist;
    logic                eval_level;
    logic                eval_rise;
    logic                eval_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_raw;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ch_q    <= ch_d;
        end
    end

    // Dropping enable clears the scan position; any tick in that cycle still completes.
    always_comb begin
        state_d = state_q;
        presc_d = '0;
        ch_d    = '0;
        case (state_q)
            IDLE: if (enable) state_d = RUN;
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    ch_d    = tick ? (last_ch ? '0 : ch_q + 1'b1) : ch_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tick    = (state_q == RUN) && (presc_q == PRESC_LAST);
        last_ch = (ch_q == CH_LAST);
    end

    debounce_eval #(
        .HIST_LEN (HIST_LEN)
    ) u_eval (
        .hist_i     (hist_q[ch_q]),
        .sample_i   (sync2_q[ch_q]),
        .level_i    (deb_q[ch_q]),
        .new_hist_o (eval_hist),
        .level_o    (eval_level),
        .rise_o     (eval_rise),
        .fall_o     (eval_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_INPUTS; i++) hist_q[i] <= '0;
            deb_q       <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            scan_done_q <= 1'b0;
        end else begin
            rise_q      <= '0;
            fall_q      <= '0;
            scan_done_q <= 1'b0;
            if (tick) begin
                hist_q[ch_q] <= eval_hist;
                deb_q[ch_q]  <= eval_level;
                rise_q[ch_q] <= eval_rise;
                fall_q[ch_q] <= eval_fall;
                scan_done_q  <= last_ch;
            end
        end
    end

    assign debounced = deb_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// tb/tb_debounce_scheduler.sv - scoreboard bench for debounce_scheduler (4 inputs, 4-deep, /4)
module tb_debounce_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] in_raw;
    logic [3:0] debounced, rise, fall;
    logic       scan_done;

    typedef struct packed {
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] deb;
    } ev_t;

    ev_t exp_q[$];
    int  ev_cyc_q[$];
    int  vecs = 0;
    int  fails = 0;
    int  cyc = 0;
    int  sd_count = 0;
    int  sd_cyc = 0;
    int  c0, s1, s2, s3, s4, sdc;

    debounce_scheduler #(
        .N_INPUTS (4),
        .HIST_LEN (4),
        .TICK_DIV (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_raw    (in_raw),
        .debounced (debounced),
        .rise      (rise),
        .fall      (fall),
        .scan_done (scan_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if ((rise | fall) != 4'b0) begin
                ev_t e;
                ev_cyc_q.push_back(cyc);
                vecs++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got rise=%b fall=%b deb=%b, required no event",
                             rise, fall, debounced);
                end else begin
                    e = exp_q.pop_front();
                    if ({rise, fall, debounced} !== e) begin
                        fails++;
                        $display("FAIL event: got rise=%b fall=%b deb=%b, required rise=%b fall=%b deb=%b",
                                 rise, fall, debounced, e.rise, e.fall, e.deb);
                    end
                end
            end
            if (scan_done) begin
                sd_count++;
                sd_cyc = cyc;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        vecs++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] r, input logic [3:0] f, input logic [3:0] d);
        ev_t e;
        e.rise = r;
        e.fall = f;
        e.deb  = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            vecs++;
            fails++;
            $display("FAIL %s_timeout: got %0d events pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_sd(input string name, input int budget, output int at);
        int start = sd_count;
        int n = 0;
        while (sd_count == start && n < budget) begin
            step(1);
            n++;
        end
        if (sd_count == start) begin
            vecs++;
            fails++;
            $display("FAIL %s_timeout: got no scan_done in %0d cycles, required one", name, budget);
            at = -1;
        end else begin
            at = sd_cyc;
        end
    endtask

    function automatic int first_ev();
        return (ev_cyc_q.size() > 0) ? ev_cyc_q[0] : -1;
    endfunction

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        in_raw = 4'b1111;
        step(2);
        check("rst_debounced", int'(debounced), 0);
        check("rst_rise", int'(rise), 0);
        check("rst_fall", int'(fall), 0);
        check("rst_scan_done", int'(scan_done), 0);

        // Disabled with all inputs high: nothing may move.
        reset = 1'b0;
        step(200);
        check("dis_debounced", int'(debounced), 0);
        check("dis_scan_done_count", sd_count, 0);

        // ch2 ticks at edges 12,28,44,60 after enable; rise visible 61 cycles later.
        ev_cyc_q.delete();
        push(4'b0100, 4'b0000, 4'b0100);
        c0     = cyc;
        in_raw = 4'b0100;
        enable = 1'b1;
        wait_empty("rise2", 120);
        check("rise2_latency", first_ev() - c0, 61);

        // A 24-cycle half period lets at most two consecutive 16-cycle samples agree.
        for (int k = 0; k < 10; k++) begin
            in_raw[0] = ~in_raw[0];
            step(24);
        end
        check("glitch_debounced", int'(debounced), 4'b0100);

        step(80);
        wait_sd("align4", 40, s1);
        in_raw = 4'b1111;
        push(4'b0001, 4'b0000, 4'b0101);
        push(4'b0010, 4'b0000, 4'b0111);
        push(4'b1000, 4'b0000, 4'b1111);
        wait_sd("scan_a", 40, s2);
        wait_sd("scan_b", 40, s3);
        check("scan_period_1", s3 - s2, 16);
        wait_sd("scan_c", 40, s4);
        check("scan_period_2", s4 - s3, 16);
        wait_empty("rise_order", 100);
        check("all_high", int'(debounced), 4'b1111);

        enable = 1'b0;
        in_raw = 4'b0000;
        step(2);
        sdc = sd_count;
        step(100);
        check("held_levels", int'(debounced), 4'b1111);
        check("held_no_scan", sd_count, sdc);

        // Restart from ch0 after a full prescaler wait: ch0 ticks at edges 4,20,36,52.
        ev_cyc_q.delete();
        push(4'b0000, 4'b0001, 4'b1110);
        push(4'b0000, 4'b0010, 4'b1100);
        push(4'b0000, 4'b0100, 4'b1000);
        push(4'b0000, 4'b1000, 4'b0000);
        c0     = cyc;
        enable = 1'b1;
        wait_empty("fall_order", 150);
        check("reenable_latency", first_ev() - c0, 53);

        wait_sd("align6", 40, s1);
        in_raw = 4'b0101;
        push(4'b0001, 4'b0000, 4'b0001);
        push(4'b0100, 4'b0000, 4'b0101);
        wait_empty("rise_0101", 120);
        check("pre_reset_levels", int'(debounced), 4'b0101);

        wait_sd("align_rst", 40, s1);
        step(6);
        #2 reset = 1'b1;
        #1;
        check("async_debounced", int'(debounced), 0);
        check("async_rise", int'(rise), 0);
        check("async_fall", int'(fall), 0);
        check("async_scan_done", int'(scan_done), 0);
        step(2);

        ev_cyc_q.delete();
        push(4'b0001, 4'b0000, 4'b0001);
        push(4'b0100, 4'b0000, 4'b0101);
        c0    = cyc;
        reset = 1'b0;
        wait_sd("post_rst_scan", 40, s1);
        check("post_rst_scan_done", s1 - c0, 17);
        wait_empty("post_rst", 120);
        check("post_rst_rise0", first_ev() - c0, 53);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
